mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute ALU.
- Registers the ALU's mem-bound outputs and waits for the dcache load response.
- Performs load byte/halfword extraction with sign or zero extension, then presents one write-back record to the WB stage.
- Drives the stall fed back to the ALU's `pause_mem_i` while a load is outstanding.

Parameters:
- `RESP_TIMEOUT`, default 0: cycles to wait in WAIT_RESP before flagging a bus error. 0 disables the timeout.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: pipeline flush from ctrl.
- `valid_i` input 1: ALU presents an instruction this cycle.
- `pc_i` input 32: instruction PC.
- `aluop_i` input 8: ALU opcode, decoded with the shared `ALU_*` macros from defines.vh.
- `addr_i` input 32: effective address (`addr_mem`).
- `is_exception_i` input 5: exception flags from upstream.
- `reg_write_en_i` input 1: upstream register write enable.
- `reg_write_addr_i` input 5: upstream register write address.
- `reg_write_data_i` input 32: upstream register write data.
- `dcache_rvalid_i` input 1: dcache load data valid.
- `dcache_rdata_i` input 32: dcache aligned word.
- `pause_wb_i` input 1: WB cannot accept this cycle.
- `pause_mem_o` output 1: stall request to the ALU and ctrl.
- `wb_valid_o` output 1: write-back record valid.
- `wb_pc_o` output 32: PC of the write-back record.
- `wb_reg_write_en_o` output 1: register write enable to WB.
- `wb_reg_write_addr_o` output 5: register write address to WB.
- `wb_reg_write_data_o` output 32: register write data to WB.
- `wb_is_exception_o` output 6: `{is_exception_i, bus_err}`.

Behaviour:
- Clocking and reset: single clock `clk`; `rst` is asynchronous, active-high.
- Reset values:
  - state = IDLE.
  - All `wb_*` outputs 0.
  - `pause_mem_o` = 0.
  - Internal timeout counter = 0.
- Load classification: `is_load` = `aluop_i` in {LDB, LDBU, LDH, LDHU, LDW, LLW} with `is_exception_i == 0`.
- States: IDLE, WAIT_RESP, HOLD, DRAIN.
- Accept rule: capture all inputs into stage registers when `valid_i` is high and the state is IDLE, or HOLD with `!pause_wb_i`. Back-to-back accept at full throughput.
- Non-load (including stores, exceptions, and SC.W): go to HOLD the next cycle with data = `reg_write_data_i` (1-cycle latency).
- Load: go to WAIT_RESP.
- WAIT_RESP:
  - `pause_mem_o` = 1.
  - On `dcache_rvalid_i`, extract using the latched `addr[1:0]`, then go to HOLD.
  - Extraction:
    - LDB: sign-extend byte[addr*8+:8].
    - LDBU: zero-extend byte[addr*8+:8].
    - LDH: sign-extend half at addr[1].
    - LDHU: zero-extend half at addr[1].
    - LDW and LLW: full word.
  - Data arriving in the cycle of entry is accepted (0-wait dcache allowed).
- HOLD:
  - `wb_valid_o` = 1 with registered fields.
  - Stays while `pause_wb_i` is high; outputs remain stable.
  - If `!pause_wb_i`: accept a new instruction if `valid_i` is high, otherwise go to IDLE.
- Exception: any set bit in `wb_is_exception_o` forces `wb_reg_write_en_o` = 0.
- Flush:
  - From IDLE or HOLD: go to IDLE next cycle and drop `wb_valid_o`.
  - From WAIT_RESP: go to DRAIN.
  - DRAIN: `pause_mem_o` = 1; discard the first `dcache_rvalid_i`, then go to IDLE.
  - Flush coinciding with `dcache_rvalid_i` in WAIT_RESP: go straight to IDLE; the data is discarded.
- Priority: flush overrides accept and response.
- `pause_mem_o` is registered-state-based, not combinational from `valid_i`, so no comb loop with the ALU.
- Timeout (when `RESP_TIMEOUT` > 0):
  - Counter increments each cycle in WAIT_RESP and clears on exit.
  - When the counter reaches `RESP_TIMEOUT`: set `bus_err`, data = 0, go to HOLD.

Optional Feature:
- Macro: `MEM_FORWARD_EN`.
- With the macro defined, add outputs `fwd_valid_o` (1), `fwd_addr_o` (5), `fwd_data_o` (32).
  - `fwd_valid_o` = state HOLD && `wb_reg_write_en_o`; the other two carry the HOLD register fields.
  - During WAIT_RESP, `fwd_valid_o` = 0 and a load-use stall is signalled via `pause_mem_o`.
- Without the macro, these ports do not exist.

Test Plan:
- ADD-class op, `reg_write_data_i`=0x12345678, `addr_i`=0 → next cycle `wb_valid_o`=1, data 0x12345678, `pause_mem_o` never 1.
- LDB at addr 0x1003, rdata 0x80FF_0000 returned 2 cycles later → `pause_mem_o` high 3 cycles, `wb_reg_write_data_o`=0xFFFFFF80.
- LDHU at addr 0x2002 and LDH at 0x2000 on the same rdata 0x8001_7FFE → 0x00008001, then 0x00007FFE.
- Flush during WAIT_RESP, rvalid 1 cycle later with 0xDEADBEEF → no `wb_valid_o`; state IDLE after the drain; the next ADD completes normally.
- `pause_wb_i` held 3 cycles while in HOLD with `valid_i`=1 → outputs stable, new instruction accepted on the 4th cycle only.
- `RESP_TIMEOUT`=4, no rvalid → after 4 WAIT_RESP cycles `wb_is_exception_o`[0]=1, `wb_reg_write_en_o`=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Signal bundle between the execute ALU, the dcache response path and the WB stage.
// fwd_* signals are present only when MEM_FORWARD_EN is defined.
interface mem_stage_if;
  logic        flush;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [7:0]  aluop_i;
  logic [31:0] addr_i;
  logic [4:0]  is_exception_i;
  logic        reg_write_en_i;
  logic [4:0]  reg_write_addr_i;
  logic [31:0] reg_write_data_i;
  logic        dcache_rvalid_i;
  logic [31:0] dcache_rdata_i;
  logic        pause_wb_i;
  logic        pause_mem_o;
  logic        wb_valid_o;
  logic [31:0] wb_pc_o;
  logic        wb_reg_write_en_o;
  logic [4:0]  wb_reg_write_addr_o;
  logic [31:0] wb_reg_write_data_o;
  logic [5:0]  wb_is_exception_o;
`ifdef MEM_FORWARD_EN
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
`endif

  modport master (
    output flush, valid_i, pc_i, aluop_i, addr_i, is_exception_i,
           reg_write_en_i, reg_write_addr_i, reg_write_data_i,
           dcache_rvalid_i, dcache_rdata_i, pause_wb_i,
    input  pause_mem_o, wb_valid_o, wb_pc_o, wb_reg_write_en_o,
           wb_reg_write_addr_o, wb_reg_write_data_o, wb_is_exception_o
`ifdef MEM_FORWARD_EN
    , input fwd_valid_o, fwd_addr_o, fwd_data_o
`endif
  );

  modport slave (
    input  flush, valid_i, pc_i, aluop_i, addr_i, is_exception_i,
           reg_write_en_i, reg_write_addr_i, reg_write_data_i,
           dcache_rvalid_i, dcache_rdata_i, pause_wb_i,
    output pause_mem_o, wb_valid_o, wb_pc_o, wb_reg_write_en_o,
           wb_reg_write_addr_o, wb_reg_write_data_o, wb_is_exception_o
`ifdef MEM_FORWARD_EN
    , output fwd_valid_o, fwd_addr_o, fwd_data_o
`endif
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: registers ALU results, waits for dcache loads, extracts/extends
// load data and presents one write-back record. Define MEM_FORWARD_EN for the fwd_* outputs.
`ifndef ALU_LDB
`define ALU_LDB  8'h20
`endif
`ifndef ALU_LDBU
`define ALU_LDBU 8'h21
`endif
`ifndef ALU_LDH
`define ALU_LDH  8'h22
`endif
`ifndef ALU_LDHU
`define ALU_LDHU 8'h23
`endif
`ifndef ALU_LDW
`define ALU_LDW  8'h24
`endif
`ifndef ALU_LLW
`define ALU_LLW  8'h25
`endif

module mem_stage #(
  parameter int RESP_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_RESP, HOLD, DRAIN} state_t;

  localparam bit          TIMEOUT_EN   = (RESP_TIMEOUT > 0);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(RESP_TIMEOUT - 1) : 32'd0;

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] pc_reg;
  logic [7:0]  aluop_reg;
  logic [1:0]  addr_lo_reg;
  logic [4:0]  exc_reg;
  logic        bus_err_reg;
  logic        we_reg;
  logic [4:0]  waddr_reg;
  logic [31:0] data_reg;

  logic        is_load;
  logic        accept;
  logic        resp_take;
  logic        timeout_hit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        wb_we;
  logic        unused_addr;

  assign unused_addr = ^bus.addr_i[31:2];

  always_comb begin
    is_load = 1'b0;
    case (bus.aluop_i)
      `ALU_LDB, `ALU_LDBU, `ALU_LDH, `ALU_LDHU, `ALU_LDW, `ALU_LLW:
        is_load = (bus.is_exception_i == 5'd0);
      default: is_load = 1'b0;
    endcase
  end

  // Flush is checked first in every state so it overrides accept and response.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = 32'd0;
    accept      = 1'b0;
    resp_take   = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!bus.flush && bus.valid_i) begin
          accept     = 1'b1;
          state_next = is_load ? WAIT_RESP : HOLD;
        end
      end
      WAIT_RESP: begin
        if (bus.flush) begin
          state_next = bus.dcache_rvalid_i ? IDLE : DRAIN;
        end else if (bus.dcache_rvalid_i) begin
          resp_take  = 1'b1;
          state_next = HOLD;
        end else if (TIMEOUT_EN && (cnt_reg == TIMEOUT_LAST)) begin
          timeout_hit = 1'b1;
          state_next  = HOLD;
        end else begin
          cnt_next = TIMEOUT_EN ? (cnt_reg + 32'd1) : 32'd0;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (!bus.pause_wb_i) begin
          if (bus.valid_i) begin
            accept     = 1'b1;
            state_next = is_load ? WAIT_RESP : HOLD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        if (bus.dcache_rvalid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    case (addr_lo_reg)
      2'd1:    byte_sel = bus.dcache_rdata_i[15:8];
      2'd2:    byte_sel = bus.dcache_rdata_i[23:16];
      2'd3:    byte_sel = bus.dcache_rdata_i[31:24];
      default: byte_sel = bus.dcache_rdata_i[7:0];
    endcase
    half_sel  = addr_lo_reg[1] ? bus.dcache_rdata_i[31:16] : bus.dcache_rdata_i[15:0];
    load_data = bus.dcache_rdata_i;
    case (aluop_reg)
      `ALU_LDB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      `ALU_LDBU: load_data = {24'd0, byte_sel};
      `ALU_LDH:  load_data = {{16{half_sel[15]}}, half_sel};
      `ALU_LDHU: load_data = {16'd0, half_sel};
      default:   load_data = bus.dcache_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg      <= 32'd0;
      aluop_reg   <= 8'd0;
      addr_lo_reg <= 2'd0;
      exc_reg     <= 5'd0;
      bus_err_reg <= 1'b0;
      we_reg      <= 1'b0;
      waddr_reg   <= 5'd0;
      data_reg    <= 32'd0;
    end else if (accept) begin
      pc_reg      <= bus.pc_i;
      aluop_reg   <= bus.aluop_i;
      addr_lo_reg <= bus.addr_i[1:0];
      exc_reg     <= bus.is_exception_i;
      bus_err_reg <= 1'b0;
      we_reg      <= bus.reg_write_en_i;
      waddr_reg   <= bus.reg_write_addr_i;
      data_reg    <= bus.reg_write_data_i;
    end else if (resp_take) begin
      data_reg    <= load_data;
    end else if (timeout_hit) begin
      data_reg    <= 32'd0;
      bus_err_reg <= 1'b1;
    end
  end

  // Any exception bit, including a bus error, suppresses the register write.
  assign wb_we = we_reg && ({exc_reg, bus_err_reg} == 6'd0);

  assign bus.pause_mem_o         = (state_reg == WAIT_RESP) || (state_reg == DRAIN);
  assign bus.wb_valid_o          = (state_reg == HOLD);
  assign bus.wb_pc_o             = pc_reg;
  assign bus.wb_reg_write_en_o   = wb_we;
  assign bus.wb_reg_write_addr_o = waddr_reg;
  assign bus.wb_reg_write_data_o = data_reg;
  assign bus.wb_is_exception_o   = {exc_reg, bus_err_reg};

`ifdef MEM_FORWARD_EN
  assign bus.fwd_valid_o = (state_reg == HOLD) && wb_we;
  assign bus.fwd_addr_o  = waddr_reg;
  assign bus.fwd_data_o  = data_reg;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_mem_stage;
  localparam int TO = 4;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_SB   = 8'h28;
  localparam logic [7:0] OP_SW   = 8'h2A;
  localparam logic [7:0] OP_SC   = 8'h2B;
  localparam logic [7:0] OP_LDB  = 8'h20;
  localparam logic [7:0] OP_LDBU = 8'h21;
  localparam logic [7:0] OP_LDH  = 8'h22;
  localparam logic [7:0] OP_LDHU = 8'h23;
  localparam logic [7:0] OP_LDW  = 8'h24;
  localparam logic [7:0] OP_LLW  = 8'h25;
  localparam logic [7:0] OPS [11] = '{OP_ADD, OP_SUB, OP_SB, OP_SW, OP_SC,
                                      OP_LDB, OP_LDBU, OP_LDH, OP_LDHU, OP_LDW, OP_LLW};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus ();
  mem_stage #(.RESP_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vec_cnt;
  int err_cnt;
  bit chk_en;

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] data;
    logic [5:0]  exc;
  } rec_t;

  rec_t       m_rec, m_ld, m_new;
  logic [7:0] m_ld_op;
  logic [1:0] m_ld_a;
  bit         m_have, m_busy, m_drain;
  int         m_wait;

  function automatic bit load_op(logic [7:0] op);
    return op inside {OP_LDB, OP_LDBU, OP_LDH, OP_LDHU, OP_LDW, OP_LLW};
  endfunction

  function automatic logic [31:0] extract(logic [7:0] op, logic [1:0] a, logic [31:0] w);
    logic [31:0] sb, sh;
    sb = w >> (8 * int'(a));
    sh = w >> (16 * int'(a[1]));
    case (op)
      OP_LDB:  return 32'($signed(sb[7:0]));
      OP_LDBU: return sb & 32'h0000_00FF;
      OP_LDH:  return 32'($signed(sh[15:0]));
      OP_LDHU: return sh & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_have = 0; m_busy = 0; m_drain = 0; m_wait = 0;
    end else if (m_drain) begin
      if (bus.dcache_rvalid_i) m_drain = 0;
    end else if (m_busy) begin
      if (bus.flush) begin
        m_busy  = 0;
        m_drain = !bus.dcache_rvalid_i;
      end else if (bus.dcache_rvalid_i) begin
        m_rec      = m_ld;
        m_rec.data = extract(m_ld_op, m_ld_a, bus.dcache_rdata_i);
        m_have     = 1;
        m_busy     = 0;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_rec        = m_ld;
          m_rec.data   = 32'd0;
          m_rec.exc[0] = 1'b1;
          m_rec.we     = 1'b0;
          m_have       = 1;
          m_busy       = 0;
        end
      end
    end else begin
      if (m_have && !bus.pause_wb_i && !bus.flush)
        $display("wb record: pc=%h we=%0d rd=%0d data=%h exc=%b",
                 m_rec.pc, m_rec.we, m_rec.wa, m_rec.data, m_rec.exc);
      if (bus.flush) begin
        m_have = 0;
      end else if (m_have && bus.pause_wb_i) begin
        m_have = 1;
      end else if (bus.valid_i) begin
        m_new.pc   = bus.pc_i;
        m_new.exc  = {bus.is_exception_i, 1'b0};
        m_new.we   = bus.reg_write_en_i && (bus.is_exception_i == 5'd0);
        m_new.wa   = bus.reg_write_addr_i;
        m_new.data = bus.reg_write_data_i;
        if (load_op(bus.aluop_i) && bus.is_exception_i == 5'd0) begin
          m_ld    = m_new;
          m_ld_op = bus.aluop_i;
          m_ld_a  = bus.addr_i[1:0];
          m_busy  = 1;
          m_wait  = 0;
          m_have  = 0;
        end else begin
          m_rec  = m_new;
          m_have = 1;
        end
      end else begin
        m_have = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check32("pause_mem", 32'(bus.pause_mem_o), 32'(m_busy || m_drain));
      check32("wb_valid", 32'(bus.wb_valid_o), 32'(m_have));
      if (m_have) begin
        check32("wb_pc", bus.wb_pc_o, m_rec.pc);
        check32("wb_we", 32'(bus.wb_reg_write_en_o), 32'(m_rec.we));
        check32("wb_addr", 32'(bus.wb_reg_write_addr_o), 32'(m_rec.wa));
        check32("wb_data", bus.wb_reg_write_data_o, m_rec.data);
        check32("wb_exc", 32'(bus.wb_is_exception_o), 32'(m_rec.exc));
      end
`ifdef MEM_FORWARD_EN
      check32("fwd_valid", 32'(bus.fwd_valid_o), 32'(m_have && m_rec.we));
      if (m_have) begin
        check32("fwd_addr", 32'(bus.fwd_addr_o), 32'(m_rec.wa));
        check32("fwd_data", bus.fwd_data_o, m_rec.data);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr_in();
    bus.valid_i          = 1'b0;
    bus.flush            = 1'b0;
    bus.dcache_rvalid_i  = 1'b0;
    bus.pause_wb_i       = 1'b0;
  endtask

  task automatic issue(logic [7:0] op, logic [31:0] addr, logic [31:0] wd,
                       logic [4:0] wa, logic [31:0] pc, logic [4:0] exc);
    bus.valid_i          = 1'b1;
    bus.aluop_i          = op;
    bus.addr_i           = addr;
    bus.reg_write_data_i = wd;
    bus.reg_write_addr_i = wa;
    bus.reg_write_en_i   = 1'b1;
    bus.pc_i             = pc;
    bus.is_exception_i   = exc;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    chk_en  = 0;
    rst     = 1'b1;
    clr_in();
    bus.aluop_i = 8'd0; bus.addr_i = 32'd0; bus.pc_i = 32'd0;
    bus.is_exception_i = 5'd0; bus.reg_write_en_i = 1'b0;
    bus.reg_write_addr_i = 5'd0; bus.reg_write_data_i = 32'd0;
    bus.dcache_rdata_i = 32'd0;
    repeat (3) @(negedge clk);
    check32("rst_pause", 32'(bus.pause_mem_o), 32'd0);
    check32("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check32("rst_wb_pc", bus.wb_pc_o, 32'd0);
    check32("rst_wb_data", bus.wb_reg_write_data_o, 32'd0);
    check32("rst_wb_we", 32'(bus.wb_reg_write_en_o), 32'd0);
    check32("rst_wb_exc", 32'(bus.wb_is_exception_o), 32'd0);
    rst = 1'b0;
    chk_en = 1;

    // ADD: one-cycle latency, no stall
    issue(OP_ADD, 32'h0, 32'h1234_5678, 5'd3, 32'h100, 5'd0);
    @(negedge clk); bus.valid_i = 1'b0;
    check32("add_valid", 32'(bus.wb_valid_o), 32'd1);
    check32("add_data", bus.wb_reg_write_data_o, 32'h1234_5678);
    check32("add_pause", 32'(bus.pause_mem_o), 32'd0);
    @(negedge clk);

    // LDB with the response arriving in the third wait cycle
    issue(OP_LDB, 32'h1003, 32'hAAAA, 5'd4, 32'h104, 5'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus.valid_i = 1'b0;
      check32("ldb_pause", 32'(bus.pause_mem_o), 32'd1);
      if (k == 2) begin bus.dcache_rvalid_i = 1'b1; bus.dcache_rdata_i = 32'h80FF_0000; end
    end
    @(negedge clk); bus.dcache_rvalid_i = 1'b0;
    check32("ldb_valid", 32'(bus.wb_valid_o), 32'd1);
    check32("ldb_data", bus.wb_reg_write_data_o, 32'hFFFF_FF80);
    check32("ldb_pause_end", 32'(bus.pause_mem_o), 32'd0);

    // LDHU then LDH on the same word, zero-wait responses
    issue(OP_LDHU, 32'h2002, 32'd0, 5'd6, 32'h108, 5'd0);
    @(negedge clk); bus.valid_i = 1'b0;
    bus.dcache_rvalid_i = 1'b1; bus.dcache_rdata_i = 32'h8001_7FFE;
    @(negedge clk); bus.dcache_rvalid_i = 1'b0;
    check32("ldhu_data", bus.wb_reg_write_data_o, 32'h0000_8001);
    issue(OP_LDH, 32'h2000, 32'd0, 5'd7, 32'h10C, 5'd0);
    @(negedge clk); bus.valid_i = 1'b0; bus.dcache_rvalid_i = 1'b1;
    @(negedge clk); bus.dcache_rvalid_i = 1'b0;
    check32("ldh_data", bus.wb_reg_write_data_o, 32'h0000_7FFE);

    // Flush while waiting: response is drained and dropped
    issue(OP_LDW, 32'h3000, 32'd0, 5'd8, 32'h110, 5'd0);
    @(negedge clk); bus.valid_i = 1'b0; bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0;
    bus.dcache_rvalid_i = 1'b1; bus.dcache_rdata_i = 32'hDEAD_BEEF;
    check32("drain_pause", 32'(bus.pause_mem_o), 32'd1);
    check32("drain_valid", 32'(bus.wb_valid_o), 32'd0);
    @(negedge clk); bus.dcache_rvalid_i = 1'b0;
    check32("post_drain_valid", 32'(bus.wb_valid_o), 32'd0);
    check32("post_drain_pause", 32'(bus.pause_mem_o), 32'd0);
    issue(OP_ADD, 32'h0, 32'h0BAD_F00D, 5'd9, 32'h114, 5'd0);
    @(negedge clk); bus.valid_i = 1'b0;
    check32("post_drain_add", bus.wb_reg_write_data_o, 32'h0BAD_F00D);

    // WB back-pressure for three cycles with a new instruction waiting
    issue(OP_ADD, 32'h0, 32'h1111_1111, 5'd10, 32'h118, 5'd0);
    @(negedge clk);
    bus.pause_wb_i = 1'b1;
    issue(OP_ADD, 32'h0, 32'h2222_2222, 5'd11, 32'h11C, 5'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check32("hold_valid", 32'(bus.wb_valid_o), 32'd1);
      check32("hold_data", bus.wb_reg_write_data_o, 32'h1111_1111);
      check32("hold_pc", bus.wb_pc_o, 32'h118);
      if (k == 2) bus.pause_wb_i = 1'b0;
    end
    @(negedge clk); bus.valid_i = 1'b0;
    check32("hold_next_data", bus.wb_reg_write_data_o, 32'h2222_2222);
    check32("hold_next_pc", bus.wb_pc_o, 32'h11C);
    @(negedge clk);

    // Response timeout raises bus error and suppresses the write
    issue(OP_LDW, 32'h4000, 32'h55, 5'd12, 32'h120, 5'd0);
    for (int k = 0; k < TO; k++) begin
      @(negedge clk); bus.valid_i = 1'b0;
      check32("to_pause", 32'(bus.pause_mem_o), 32'd1);
    end
    @(negedge clk);
    check32("to_valid", 32'(bus.wb_valid_o), 32'd1);
    check32("to_exc", 32'(bus.wb_is_exception_o), 32'h01);
    check32("to_we", 32'(bus.wb_reg_write_en_o), 32'd0);
    check32("to_data", bus.wb_reg_write_data_o, 32'd0);

    // Upstream exception on a load behaves as a non-load with write disabled
    issue(OP_LDW, 32'h5000, 32'h77, 5'd13, 32'h124, 5'b00100);
    @(negedge clk); bus.valid_i = 1'b0;
    check32("exc_valid", 32'(bus.wb_valid_o), 32'd1);
    check32("exc_we", 32'(bus.wb_reg_write_en_o), 32'd0);
    check32("exc_bits", 32'(bus.wb_is_exception_o), 32'h08);
    check32("exc_pause", 32'(bus.pause_mem_o), 32'd0);
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.valid_i          = ($urandom_range(0, 99) < 55);
      bus.aluop_i          = OPS[$urandom_range(0, 10)];
      bus.pc_i             = $urandom;
      bus.addr_i           = $urandom;
      bus.is_exception_i   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      bus.reg_write_en_i   = 1'($urandom_range(0, 1));
      bus.reg_write_addr_i = 5'($urandom_range(0, 31));
      bus.reg_write_data_i = $urandom;
      bus.flush            = ($urandom_range(0, 99) < 5);
      bus.pause_wb_i       = ($urandom_range(0, 99) < 25);
      bus.dcache_rvalid_i  = (m_busy || m_drain) && ($urandom_range(0, 99) < 40);
      bus.dcache_rdata_i   = $urandom;
    end
    @(negedge clk);
    clr_in();
    repeat (8) @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
